// File: rtl/rf_sequencer.sv
// rtl/rf_sequencer.sv - command sequencer driving register file control words
module rf_sequencer (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [2:0]  op_i,
   input  logic [2:0]  dst_i,
   input  logic [2:0]  src_i,
   input  logic [15:0] imm_i,
   input  logic [15:0] rf_out_a_i,
   output logic [2:0]  fun_sel_o,
   output logic [3:0]  reg_sel_o,
   output logic [3:0]  scr_sel_o,
   output logic [2:0]  out_a_sel_o,
   output logic [2:0]  out_b_sel_o,
   output logic [15:0] i_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STEP1 = 3'd1,
      S_STEP2 = 3'd2,
      S_STEP3 = 3'd3,
      S_CNT   = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam logic [2:0] OP_LOADI = 3'b000;
   localparam logic [2:0] OP_CLR   = 3'b001;
   localparam logic [2:0] OP_INC   = 3'b010;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_MOV   = 3'b100;
   localparam logic [2:0] OP_SWAP  = 3'b101;
   localparam logic [2:0] OP_ADDN  = 3'b110;
   localparam logic [2:0] OP_ILL   = 3'b111;

   localparam logic [2:0] FUN_DEC  = 3'b000;
   localparam logic [2:0] FUN_INC  = 3'b001;
   localparam logic [2:0] FUN_LOAD = 3'b010;
   localparam logic [2:0] FUN_CLR  = 3'b011;

   // S4 is the scratch slot SWAP parks the source value in
   localparam logic [2:0] IDX_S4   = 3'd7;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [2:0]  dst_q, dst_d;
   logic [2:0]  src_q, src_d;
   logic [15:0] imm_q, imm_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  sel_q, sel_d;      // {RegSel, ScrSel}, active low
   logic [2:0]  fun_q, fun_d;
   logic [2:0]  a_sel_q, a_sel_d;
   logic        xfer_q, xfer_d;    // current step writes RfOutA rather than Imm
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        illegal;

   // Index 0..3 -> R1..R4 (RegSel bits 3..0), 4..7 -> S1..S4 (ScrSel bits 3..0)
   function automatic logic [7:0] enable_mask(input logic [2:0] idx);
      enable_mask = ~(8'b0000_0001 << (3'd7 - idx));
   endfunction

   assign illegal = (op_i == OP_ILL) ||
                    ((op_i == OP_SWAP) && ((src_i == IDX_S4) || (dst_i == IDX_S4)));

   // Next-state and next control word for the step being entered
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dst_d   = dst_q;
      src_d   = src_q;
      imm_d   = imm_q;
      cnt_d   = cnt_q;
      sel_d   = 8'hFF;
      fun_d   = FUN_LOAD;
      a_sel_d = 3'd0;
      xfer_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               op_d  = op_i;
               dst_d = dst_i;
               src_d = src_i;
               imm_d = imm_i;
               if (illegal) begin
                  state_d = S_ERR;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  case (op_i)
                     OP_LOADI: begin
                        state_d = S_STEP1;
                        sel_d   = enable_mask(dst_i);
                        fun_d   = FUN_LOAD;
                        done_d  = 1'b1;
                     end
                     OP_CLR: begin
                        state_d = S_STEP1;
                        sel_d   = enable_mask(dst_i);
                        fun_d   = FUN_CLR;
                        done_d  = 1'b1;
                     end
                     OP_INC: begin
                        state_d = S_STEP1;
                        sel_d   = enable_mask(dst_i);
                        fun_d   = FUN_INC;
                        done_d  = 1'b1;
                     end
                     OP_DEC: begin
                        state_d = S_STEP1;
                        sel_d   = enable_mask(dst_i);
                        fun_d   = FUN_DEC;
                        done_d  = 1'b1;
                     end
                     OP_MOV: begin
                        state_d = S_STEP1;
                        sel_d   = enable_mask(dst_i);
                        fun_d   = FUN_LOAD;
                        a_sel_d = src_i;
                        xfer_d  = 1'b1;
                        done_d  = 1'b1;
                     end
                     OP_SWAP: begin
                        state_d = S_STEP1;
                        sel_d   = enable_mask(IDX_S4);
                        fun_d   = FUN_LOAD;
                        a_sel_d = src_i;
                        xfer_d  = 1'b1;
                     end
                     default: begin
                        // ADDN: cnt holds the increments still to come after this cycle
                        state_d = S_CNT;
                        if (imm_i[3:0] == 4'd0) begin
                           cnt_d  = 4'd0;
                           done_d = 1'b1;
                        end else begin
                           cnt_d  = imm_i[3:0] - 4'd1;
                           sel_d  = enable_mask(dst_i);
                           fun_d  = FUN_INC;
                           done_d = (imm_i[3:0] == 4'd1);
                        end
                     end
                  endcase
               end
            end
         end
         S_STEP1: begin
            if (op_q == OP_SWAP) begin
               state_d = S_STEP2;
               sel_d   = enable_mask(src_q);
               a_sel_d = dst_q;
               xfer_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_STEP2: begin
            state_d = S_STEP3;
            sel_d   = enable_mask(dst_q);
            a_sel_d = IDX_S4;
            xfer_d  = 1'b1;
            done_d  = 1'b1;
         end
         S_CNT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               sel_d  = enable_mask(dst_q);
               fun_d  = FUN_INC;
               done_d = (cnt_q == 4'd1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register state, latched command fields and the control word
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOADI;
         dst_q   <= 3'd0;
         src_q   <= 3'd0;
         imm_q   <= 16'h0000;
         cnt_q   <= 4'd0;
         sel_q   <= 8'hFF;
         fun_q   <= FUN_LOAD;
         a_sel_q <= 3'd0;
         xfer_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         imm_q   <= imm_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         fun_q   <= fun_d;
         a_sel_q <= a_sel_d;
         xfer_q  <= xfer_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign reg_sel_o   = sel_q[7:4];
   assign scr_sel_o   = sel_q[3:0];
   assign fun_sel_o   = fun_q;
   assign out_a_sel_o = a_sel_q;
   assign out_b_sel_o = dst_q;
   assign i_o         = xfer_q ? rf_out_a_i : imm_q;
   assign busy_o      = (state_q != S_IDLE);
   assign cmd_ready_o = (state_q == S_IDLE);
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb/tb_rf_sequencer.sv - scoreboard bench for rf_sequencer with register file model
module tb_rf_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  op = 3'd0, dst = 3'd0, src = 3'd0;
   logic [15:0] imm = 16'h0;
   logic [15:0] rf_out_a;
   logic [2:0]  fun_sel;
   logic [3:0]  reg_sel, scr_sel;
   logic [2:0]  out_a_sel, out_b_sel;
   logic [15:0] i_data;
   logic        busy, done, err;

   rf_sequencer dut (
      .clk_i(clk), .resetn_i(resetn), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .op_i(op), .dst_i(dst), .src_i(src), .imm_i(imm), .rf_out_a_i(rf_out_a),
      .fun_sel_o(fun_sel), .reg_sel_o(reg_sel), .scr_sel_o(scr_sel),
      .out_a_sel_o(out_a_sel), .out_b_sel_o(out_b_sel), .i_o(i_data),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   // register file model: environment the sequencer drives
   logic [15:0] rf [8];
   logic [15:0] preload [8];
   logic        preload_en = 1'b1;
   logic [7:0]  sel_all;
   assign sel_all  = {reg_sel, scr_sel};
   assign rf_out_a = rf[out_a_sel];

   always @(posedge clk) begin
      for (int k = 0; k < 8; k++) begin
         if (preload_en) rf[k] <= preload[k];
         else if (sel_all[7-k] === 1'b0) begin
            case (fun_sel)
               3'b000:  rf[k] <= rf[k] - 16'd1;
               3'b001:  rf[k] <= rf[k] + 16'd1;
               3'b010:  rf[k] <= i_data;
               default: rf[k] <= 16'h0000;
            endcase
         end
      end
   end

   typedef struct {
      logic [7:0]  sel;
      logic [2:0]  fun;
      logic        care_a;
      logic [2:0]  a_sel;
      logic [15:0] i;
      logic [2:0]  b_sel;
      logic        done;
      logic        err;
   } step_t;

   step_t       exp_q[$];
   logic [15:0] exp_regs [8];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic        mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [7:0] en(input logic [2:0] idx);
      logic [3:0] r, s;
      r = 4'hF;
      s = 4'hF;
      if (idx < 3'd4) r[3 - idx] = 1'b0;
      else            s[7 - idx] = 1'b0;
      return {r, s};
   endfunction

   // reference model: expected per-cycle control words and register effects
   task automatic model_cmd(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s_i,
                            input logic [15:0] im);
      step_t st;
      logic [15:0] vs, vd;
      int n;
      vs = exp_regs[s_i];
      vd = exp_regs[d];
      st.sel = 8'hFF; st.fun = 3'b010; st.care_a = 1'b0; st.a_sel = 3'd0;
      st.i = im; st.b_sel = d; st.done = 1'b0; st.err = 1'b0;
      if (o == 3'd7 || (o == 3'd5 && (s_i == 3'd7 || d == 3'd7))) begin
         st.done = 1'b1; st.err = 1'b1;
         exp_q.push_back(st);
         return;
      end
      case (o)
         3'd0: begin st.sel = en(d); st.fun = 3'b010; st.done = 1'b1; exp_q.push_back(st); exp_regs[d] = im; end
         3'd1: begin st.sel = en(d); st.fun = 3'b011; st.done = 1'b1; exp_q.push_back(st); exp_regs[d] = 16'h0; end
         3'd2: begin st.sel = en(d); st.fun = 3'b001; st.done = 1'b1; exp_q.push_back(st); exp_regs[d] = vd + 16'd1; end
         3'd3: begin st.sel = en(d); st.fun = 3'b000; st.done = 1'b1; exp_q.push_back(st); exp_regs[d] = vd - 16'd1; end
         3'd4: begin
            st.sel = en(d); st.care_a = 1'b1; st.a_sel = s_i; st.i = vs; st.done = 1'b1;
            exp_q.push_back(st);
            exp_regs[d] = vs;
         end
         3'd5: begin
            st.care_a = 1'b1;
            st.sel = en(3'd7); st.a_sel = s_i;  st.i = vs; exp_q.push_back(st);
            st.sel = en(s_i);  st.a_sel = d;    st.i = vd; exp_q.push_back(st);
            st.sel = en(d);    st.a_sel = 3'd7; st.i = vs; st.done = 1'b1; exp_q.push_back(st);
            exp_regs[7] = vs; exp_regs[s_i] = vd; exp_regs[d] = vs;
         end
         default: begin
            n = int'(im[3:0]);
            if (n == 0) begin
               st.done = 1'b1;
               exp_q.push_back(st);
            end else begin
               st.sel = en(d); st.fun = 3'b001;
               for (int k = 0; k < n; k++) begin
                  st.done = (k == n - 1);
                  exp_q.push_back(st);
               end
               exp_regs[d] = vd + 16'(n);
            end
         end
      endcase
   endtask

   // monitor: compare each presented cycle against the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         check("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
         if (busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_busy_cycle", 32'd1, 32'd0);
            end else begin
               step_t e;
               e = exp_q.pop_front();
               check("step_enables", {24'd0, reg_sel, scr_sel}, {24'd0, e.sel});
               if (e.sel != 8'hFF) check("step_funsel", {29'd0, fun_sel}, {29'd0, e.fun});
               if (e.care_a) check("step_outasel", {29'd0, out_a_sel}, {29'd0, e.a_sel});
               check("step_i", {16'd0, i_data}, {16'd0, e.i});
               check("step_outbsel", {29'd0, out_b_sel}, {29'd0, e.b_sel});
               check("step_done_err", {30'd0, done, err}, {30'd0, e.done, e.err});
            end
         end else begin
            check("idle_enables", {24'd0, reg_sel, scr_sel}, 32'h0000_00FF);
            check("idle_done_err", {30'd0, done, err}, 32'd0);
         end
      end
   end

   task automatic randomize_inputs();
      op  = 3'($urandom);
      dst = 3'($urandom);
      src = 3'($urandom);
      imm = 16'($urandom);
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (cmd_ready !== 1'b1) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 100) begin
            check("wait_ready_timeout", 32'd1, 32'd0);
            break;
         end
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (busy !== 1'b0 || exp_q.size() != 0) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 100) begin
            check("wait_idle_timeout", 32'd1, 32'd0);
            break;
         end
      end
   endtask

   // issue one command; early=1 raises CmdValid while the sequencer may still be busy
   task automatic send(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s_i,
                       input logic [15:0] im, input bit early);
      if (!early) wait_ready();
      model_cmd(o, d, s_i, im);
      op = o; dst = d; src = s_i; imm = im;
      cmd_valid = 1'b1;
      if (early) wait_ready();
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      randomize_inputs();
   endtask

   task automatic check_regs(input string tag);
      wait_idle();
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s_reg%0d", tag, k), {16'd0, rf[k]}, {16'd0, exp_regs[k]});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_enables"}, {24'd0, reg_sel, scr_sel}, 32'h0000_00FF);
      check({tag, "_funsel"}, {29'd0, fun_sel}, 32'd2);
      check({tag, "_outasel"}, {29'd0, out_a_sel}, 32'd0);
      check({tag, "_outbsel"}, {29'd0, out_b_sel}, 32'd0);
      check({tag, "_i"}, {16'd0, i_data}, 32'd0);
      check({tag, "_flags"}, {28'd0, busy, done, err, cmd_ready}, 32'd1);
   endtask

   initial begin
      logic [15:0] saved [8];
      for (int k = 0; k < 8; k++) begin
         preload[k]  = 16'($urandom);
         exp_regs[k] = preload[k];
      end
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      preload_en = 1'b0;
      check_reset_outputs("reset");
      resetn = 1'b1;
      mon_en = 1'b1;

      // directed test plan sequence
      send(3'd0, 3'd0, 3'd0, 16'h1234, 1'b0);           // LOADI R1
      check_regs("loadi");
      send(3'd4, 3'd5, 3'd0, 16'h0000, 1'b0);           // MOV R1 -> S2
      check_regs("mov");
      send(3'd0, 3'd1, 3'd0, 16'hAAAA, 1'b0);
      send(3'd0, 3'd4, 3'd0, 16'h5555, 1'b0);
      send(3'd5, 3'd4, 3'd1, 16'h0000, 1'b0);           // SWAP R2 <-> S1
      check_regs("swap");
      send(3'd0, 3'd2, 3'd0, 16'hFFFE, 1'b0);
      send(3'd6, 3'd2, 3'd0, 16'h0003, 1'b0);           // ADDN wraps to 0x0001
      check_regs("addn");
      send(3'd6, 3'd3, 3'd0, 16'h0010, 1'b0);           // ADDN n=0
      send(3'd7, 3'd1, 3'd2, 16'h0000, 1'b0);           // illegal opcode
      send(3'd5, 3'd7, 3'd1, 16'h0000, 1'b0);           // SWAP touching S4
      send(3'd5, 3'd2, 3'd7, 16'h0000, 1'b0);
      send(3'd2, 3'd6, 3'd0, 16'h0000, 1'b1);           // back-to-back with early valid
      send(3'd3, 3'd6, 3'd0, 16'h0000, 1'b1);
      check_regs("misc");

      // reset during a SWAP, before its second step is driven
      wait_idle();
      saved = exp_regs;
      send(3'd5, 3'd4, 3'd1, 16'h0000, 1'b0);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      exp_regs = saved;
      exp_regs[7] = saved[1];
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      check_reset_outputs("abort");
      check("abort_queue_empty", exp_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_regs("abort");

      // randomized commands
      for (int t = 0; t < 80; t++) begin
         logic [2:0]  ro, rd, rs;
         logic [15:0] ri;
         ro = 3'($urandom);
         rd = 3'($urandom);
         rs = 3'($urandom);
         ri = 16'($urandom);
         send(ro, rd, rs, ri, 1'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      check_regs("final");
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
